// File: rtl/gpio_img_loader.sv
// gpio_img_loader: decodes toggle-handshaked GPIO command words from the MCU
// and writes pixels into the N+2 line-memory banks through the shared write port.
module gpio_img_loader #(
  parameter int GPIO_D      = 32,
  parameter int N           = 2,
  parameter int NB_ADDRESS  = 10,
  parameter int BITS_IMAGEN = 11
) (
  input  logic                   CLK100MHZ,
  input  logic                   i_reset_n,
  input  logic [GPIO_D-1:0]      i_gpio_data,
  output logic [GPIO_D-1:0]      o_gpio_data,
  output logic [N+1:0]           o_we,
  output logic [NB_ADDRESS-1:0]  o_WAddr,
  output logic [BITS_IMAGEN-1:0] o_MemData,
  output logic                   o_done
);

  typedef enum logic {IDLE, EXEC} state_t;
  typedef enum logic [1:0] {
    OP_CLEAR    = 2'b00,
    OP_SET_BANK = 2'b01,
    OP_SET_ADDR = 2'b10,
    OP_WRITE    = 2'b11
  } op_t;

  logic [GPIO_D-1:0]     s1, s2;
  state_t                state, state_d;
  logic                  accept;
  op_t                   op;
  logic [10:0]           pl;
  logic                  req_prev;
  logic [1:0]            bank;
  logic [NB_ADDRESS-1:0] addr;
  logic                  ack, done, err;
  logic [N+1:0]          we_onehot;
  logic                  unused_bits;

  assign unused_bits = ^{s2[GPIO_D-1:27], s2[15:5], s2[1:0], pl[10]};

  always_ff @(posedge CLK100MHZ) begin
    s1 <= i_gpio_data;
    s2 <= s1;
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_d;
  end

  always_comb begin
    state_d = state;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        if (s2[2] != req_prev) begin
          accept  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: state_d = IDLE;
    endcase
  end

  always_comb begin
    we_onehot = '0;
    for (int unsigned i = 0; i < N + 2; i++) begin
      we_onehot[i] = (bank == 2'(i));
    end
  end

  // The write strobe is launched from the synchronizer word at acceptance so
  // it is valid exactly during EXEC, using the bank/addr before this command.
  always_ff @(posedge CLK100MHZ) begin
    if (!i_reset_n) begin
      req_prev  <= s2[2];
      op        <= OP_CLEAR;
      pl        <= '0;
      bank      <= '0;
      addr      <= '0;
      ack       <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      o_we      <= '0;
      o_WAddr   <= '0;
      o_MemData <= '0;
    end else begin
      o_we <= '0;
      if (accept) begin
        req_prev <= s2[2];
        op       <= op_t'(s2[4:3]);
        pl       <= s2[26:16];
        if (op_t'(s2[4:3]) == OP_WRITE) begin
          o_we      <= we_onehot;
          o_WAddr   <= addr;
          o_MemData <= s2[16 +: BITS_IMAGEN];
        end
      end
      if (state == EXEC) begin
        ack <= ~ack;
        case (op)
          OP_CLEAR: begin
            bank <= '0;
            addr <= '0;
            done <= 1'b0;
            err  <= 1'b0;
          end
          OP_SET_BANK: begin
            if ({30'd0, pl[1:0]} <= 32'(N + 1)) bank <= pl[1:0];
            else                                err  <= 1'b1;
          end
          OP_SET_ADDR: addr <= pl[NB_ADDRESS-1:0];
          OP_WRITE: begin
            if (addr == '1) begin
              addr <= '0;
              if (bank == 2'(N + 1)) begin
                bank <= '0;
                done <= 1'b1;
              end else begin
                bank <= bank + 2'd1;
              end
            end else begin
              addr <= addr + 1'b1;
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    o_gpio_data                 = '0;
    o_gpio_data[0]              = ack;
    o_gpio_data[1]              = done;
    o_gpio_data[2]              = err;
    o_gpio_data[4:3]            = bank;
    o_gpio_data[5 +: NB_ADDRESS] = addr;
  end

  assign o_done = done;

endmodule

// File: tb/tb_gpio_img_loader.sv
// Self-checking bench for gpio_img_loader: transaction-level model with a
// per-cycle compare process, plus literal checks from hand-computed cases.
module tb_gpio_img_loader;

  localparam int N = 2;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] gin, gout;
  logic [3:0]  we;
  logic [9:0]  wa;
  logic [10:0] md;
  logic        done;

  logic [31:0] gin1, gout1;
  logic [2:0]  we1;
  logic [9:0]  wa1;
  logic [10:0] md1;
  logic        done1;

  gpio_img_loader #(.GPIO_D(32), .N(N), .NB_ADDRESS(10), .BITS_IMAGEN(11)) dut (
    .CLK100MHZ(clk), .i_reset_n(rst_n), .i_gpio_data(gin), .o_gpio_data(gout),
    .o_we(we), .o_WAddr(wa), .o_MemData(md), .o_done(done)
  );

  gpio_img_loader #(.GPIO_D(32), .N(1), .NB_ADDRESS(10), .BITS_IMAGEN(11)) dut1 (
    .CLK100MHZ(clk), .i_reset_n(rst_n), .i_gpio_data(gin1), .o_gpio_data(gout1),
    .o_we(we1), .o_WAddr(wa1), .o_MemData(md1), .o_done(done1)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { int c; logic [31:0] st; } st_ev_t;
  typedef struct { int c; logic [3:0] we; logic [9:0] a; logic [10:0] d; } we_ev_t;
  st_ev_t st_q[$];
  we_ev_t we_q[$];

  // transaction-level model of the loader registers
  int m_bank = 0, m_addr = 0, m_done = 0, m_err = 0, m_ack = 0;

  function automatic logic [31:0] mstat();
    return 32'(m_ack) | (32'(m_done) << 1) | (32'(m_err) << 2) |
           (32'(m_bank) << 3) | (32'(m_addr) << 5);
  endfunction

  int dut_mem [4096];

  // per-cycle comparison against the scheduled model expectations
  logic [31:0] exp_status = '0;
  always @(negedge clk) begin
    if (chk_en) begin
      logic [3:0]  ew;
      logic [9:0]  ea;
      logic [10:0] ed;
      while (st_q.size() > 0 && st_q[0].c <= cyc) begin
        exp_status = st_q[0].st;
        void'(st_q.pop_front());
      end
      while (we_q.size() > 0 && we_q[0].c < cyc) void'(we_q.pop_front());
      ew = '0; ea = '0; ed = '0;
      if (we_q.size() > 0 && we_q[0].c == cyc) begin
        ew = we_q[0].we; ea = we_q[0].a; ed = we_q[0].d;
        void'(we_q.pop_front());
      end
      check("o_we", 32'(we), 32'(ew));
      check("status", gout, exp_status);
      check("o_done", 32'(done), 32'(exp_status[1]));
      if (ew != 0) begin
        check("o_WAddr", 32'(wa), 32'(ea));
        check("o_MemData", 32'(md), 32'(ed));
      end
      if (we != 0 && !$isunknown({we, wa, md})) begin
        for (int b = 0; b < 4; b++) if (we[b]) dut_mem[b * 1024 + int'(wa)] = int'(md);
      end
    end
  end

  logic        req = 1'b1;
  int          we_cnt;
  logic [3:0]  last_we;
  logic [9:0]  last_wa;
  logic [10:0] last_md;

  task automatic drive(input logic [1:0] op, input logic [10:0] p);
    gin        = $urandom;
    gin[2]     = req;
    gin[4:3]   = op;
    gin[26:16] = p;
  endtask

  task automatic model_cmd(input logic [1:0] op, input logic [10:0] p);
    case (op)
      2'd0: begin m_bank = 0; m_addr = 0; m_done = 0; m_err = 0; end
      2'd1: if (int'(p[1:0]) <= N + 1) m_bank = int'(p[1:0]); else m_err = 1;
      2'd2: m_addr = int'(p) % 1024;
      2'd3: begin
        m_addr++;
        if (m_addr == 1024) begin
          m_addr = 0;
          m_bank++;
          if (m_bank == N + 2) begin m_bank = 0; m_done = 1; end
        end
      end
    endcase
    m_ack ^= 1;
  endtask

  // issue one command at a negedge and wait (bounded) for its ack
  task automatic issue(input logic [1:0] op, input logic [10:0] p);
    int   c;
    int   n;
    logic prev;
    c    = cyc;
    prev = gout[0];
    req  = ~req;
    drive(op, p);
    if (op == 2'd3) we_q.push_back('{c + 3, 4'(1 << m_bank), 10'(m_addr), p});
    model_cmd(op, p);
    st_q.push_back('{c + 4, mstat()});
    we_cnt = 0;
    for (n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (we != 0) begin we_cnt++; last_we = we; last_wa = wa; last_md = md; end
      if (gout[0] != prev) break;
    end
    check("ack_latency", 32'(n), 32'd4);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int errs;
    rst_n = 1'b0;
    gin   = $urandom;
    gin[2] = 1'b1;
    gin1  = '0;
    foreach (dut_mem[i]) dut_mem[i] = -1;
    repeat (5) @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // req held high through reset release: nothing happens
    repeat (20) @(negedge clk);
    check("rst_ack", 32'(gout[0]), 32'd0);
    check("rst_status", gout, 32'd0);

    // N=1 instance: bank 3 is out of range
    gin1[4:3] = 2'd1; gin1[26:16] = 11'd3; gin1[2] = 1'b1;
    repeat (6) @(negedge clk);
    check("n1_err", gout1, 32'h5);
    gin1[26:16] = 11'd2; gin1[2] = 1'b0;
    repeat (6) @(negedge clk);
    check("n1_bank2", gout1, 32'h14);
    check("n1_we", 32'(we1), 32'd0);

    // directed write
    issue(2'd0, 11'd0);
    issue(2'd1, 11'd2);
    issue(2'd2, 11'd5);
    issue(2'd3, 11'h3FF);
    check("w1_strobes", 32'(we_cnt), 32'd1);
    check("w1_we", 32'(last_we), 32'b0100);
    check("w1_addr", 32'(last_wa), 32'd5);
    check("w1_data", 32'(last_md), 32'h3FF);
    check("w1_status", gout, 32'hD0);

    // last address of last bank
    issue(2'd1, 11'd3);
    issue(2'd2, 11'd1023);
    issue(2'd3, 11'h001);
    check("w2_we", 32'(last_we), 32'b1000);
    check("w2_addr", 32'(last_wa), 32'd1023);
    check("w2_data", 32'(last_md), 32'h1);
    check("w2_done", 32'(done), 32'd1);
    check("w2_status", gout, 32'h3);
    issue(2'd0, 11'd0);
    check("clr_done", 32'(done), 32'd0);
    check("clr_status", gout, 32'h0);

    // full image, back to back
    foreach (dut_mem[i]) dut_mem[i] = -1;
    issue(2'd0, 11'd0);
    issue(2'd1, 11'd0);
    issue(2'd2, 11'd0);
    for (int i = 0; i < 4096; i++) begin
      if (i == 4095) check("done_before_last", 32'(done), 32'd0);
      issue(2'd3, 11'(i));
    end
    check("img_done", 32'(done), 32'd1);
    check("img_status", gout, 32'h3);
    errs = 0;
    for (int i = 0; i < 4096; i++) if (dut_mem[i] != (i % 2048)) errs++;
    check("image_contents", 32'(errs), 32'd0);

    // random commands with random gaps
    for (int k = 0; k < 300; k++) begin
      int r;
      logic [1:0] op;
      r  = int'($urandom_range(0, 9));
      op = (r < 6) ? 2'd3 : (r < 7) ? 2'd0 : (r < 8) ? 2'd1 : 2'd2;
      issue(op, 11'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // reset during EXEC of a WRITE aborts it
    begin
      int c;
      c   = cyc;
      req = ~req;
      drive(2'd3, 11'h155);
      we_q.push_back('{c + 3, 4'(1 << m_bank), 10'(m_addr), 11'h155});
      m_bank = 0; m_addr = 0; m_done = 0; m_err = 0; m_ack = 0;
      st_q.push_back('{c + 4, 32'd0});
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      check("abort_status", gout, 32'd0);
      check("abort_we", 32'(we), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
